// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM
// Moore outputs, except for the mem_ready gating in FETCH and the zero-driven branch enable.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_AEX    = 4'd11,
        S_AWB    = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14,
        S_UNUSED = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = S_FETCH;
        pc_en      = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'd0;
        MemtoReg   = 2'd0;
        ALUSrcB    = 2'd0;
        PCSource   = 2'd0;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                pc_en   = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = (funct == FN_JR) ? S_JR : S_REX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_AEX;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 2'd1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
            end
            S_AEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_d = S_AWB;
            end
            S_AWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'd1;
                if (op == OP_BEQ) begin
                    pc_en = zero;
                end else if (op == OP_BNE) begin
                    pc_en = ~zero;
                end
            end
            S_JUMP: begin
                PCSource = 2'd2;
                pc_en    = 1'b1;
            end
            // $31 takes the PC value before this edge's load, i.e. PC+4
            S_JAL: begin
                PCSource = 2'd2;
                pc_en    = 1'b1;
                RegDst   = 2'd2;
                MemtoReg = 2'd2;
                RegWrite = 1'b1;
            end
            S_JR: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b11;
                pc_en   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized instruction-script check of multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pc_en, IorD, ALUSrcA, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp;
    logic       illegal_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .IorD(IorD), .ALUSrcA(ALUSrcA),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .state(state)
    );

    // one expected clock cycle: state, outputs, and the inputs to drive during it
    typedef struct {
        logic [3:0]  st;
        logic [17:0] o;
        logic        mr;
        logic        z;
        logic [5:0]  opc;
        logic [5:0]  fn;
    } row_t;

    row_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk(
        input logic pce, iord, srca, mrd, mwr, irw, rw,
        input logic [1:0] rd, m2r, srcb, pcs, alu,
        input logic ill);
        return {pce, iord, srca, mrd, mwr, irw, rw, rd, m2r, srcb, pcs, alu, ill};
    endfunction

    function automatic logic [17:0] observed();
        return {pc_en, IorD, ALUSrcA, MemRead, MemWrite, IRWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, illegal_op};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [3:0] st, input logic [17:0] o, input logic mr,
                        input logic z, input logic [5:0] opc, input logic [5:0] fn);
        row_t r;
        r.st = st; r.o = o; r.mr = mr; r.z = z; r.opc = opc; r.fn = fn;
        q.push_back(r);
    endtask

    // Expected cycle script of one instruction: fw/mw are mem_ready=0 cycles in FETCH / data access.
    task automatic gen_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input int fw, input int mw, input logic zf);
        logic legal;
        logic pce;
        legal = opc inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b};
        for (int i = 0; i < fw; i++)
            push(1, mk(0,0,0,1,0,0,0, 0,0,1,0,0, 0), 0, rb(), opc, fn);
        push(1, mk(1,0,0,1,0,1,0, 0,0,1,0,0, 0), 1, rb(), opc, fn);
        push(2, mk(0,0,0,0,0,0,0, 0,0,3,0,0, !legal), rb(), rb(), opc, fn);
        case (opc)
            6'h23: begin
                push(3, mk(0,0,1,0,0,0,0, 0,0,2,0,0, 0), rb(), rb(), opc, fn);
                for (int i = 0; i < mw; i++)
                    push(4, mk(0,1,0,1,0,0,0, 0,0,0,0,0, 0), 0, rb(), opc, fn);
                push(4, mk(0,1,0,1,0,0,0, 0,0,0,0,0, 0), 1, rb(), opc, fn);
                push(5, mk(0,0,0,0,0,0,1, 0,1,0,0,0, 0), rb(), rb(), opc, fn);
            end
            6'h2b: begin
                push(3, mk(0,0,1,0,0,0,0, 0,0,2,0,0, 0), rb(), rb(), opc, fn);
                for (int i = 0; i < mw; i++)
                    push(6, mk(0,1,0,0,1,0,0, 0,0,0,0,0, 0), 0, rb(), opc, fn);
                push(6, mk(0,1,0,0,1,0,0, 0,0,0,0,0, 0), 1, rb(), opc, fn);
            end
            6'h00: begin
                if (fn == 6'h08) begin
                    push(14, mk(1,0,1,0,0,0,0, 0,0,0,0,3, 0), rb(), rb(), opc, fn);
                end else begin
                    push(7, mk(0,0,1,0,0,0,0, 0,0,0,0,2, 0), rb(), rb(), opc, fn);
                    push(8, mk(0,0,0,0,0,0,1, 1,0,0,0,0, 0), rb(), rb(), opc, fn);
                end
            end
            6'h04, 6'h05: begin
                pce = (opc == 6'h04) ? zf : ~zf;
                push(9, mk(pce,0,1,0,0,0,0, 0,0,0,1,1, 0), rb(), zf, opc, fn);
            end
            6'h08: begin
                push(11, mk(0,0,1,0,0,0,0, 0,0,2,0,0, 0), rb(), rb(), opc, fn);
                push(12, mk(0,0,0,0,0,0,1, 0,0,0,0,0, 0), rb(), rb(), opc, fn);
            end
            6'h02: push(10, mk(1,0,0,0,0,0,0, 0,0,0,2,0, 0), rb(), rb(), opc, fn);
            6'h03: push(13, mk(1,0,0,0,0,0,1, 2,2,0,2,0, 0), rb(), rb(), opc, fn);
            default: ;
        endcase
    endtask

    task automatic step(input row_t r);
        @(negedge clk);
        mem_ready = r.mr;
        zero      = r.z;
        op        = r.opc;
        funct     = r.fn;
        #1;
        check($sformatf("state(exp %0d)", r.st), 32'(state), 32'(r.st));
        check($sformatf("outputs(st %0d)", r.st), 32'(observed()), 32'(r.o));
    endtask

    task automatic drain();
        while (q.size() > 0) step(q.pop_front());
    endtask

    task automatic run(input logic [5:0] opc, input logic [5:0] fn,
                       input int fw, input int mw, input logic zf);
        gen_instr(opc, fn, fw, mw, zf);
        drain();
    endtask

    // first cycle after release: still RESET, FETCH one edge later
    task automatic release_reset();
        row_t r;
        @(negedge clk);
        rst_n = 1'b1;
        r.st = 0; r.o = '0; r.mr = 1; r.z = 0; r.opc = 6'h23; r.fn = 0;
        #1;
        check("post_release_state", 32'(state), 32'(r.st));
        check("post_release_outs", 32'(observed()), 32'(r.o));
    endtask

    logic [5:0] legal_ops [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b};

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'h23; funct = 6'h00;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'(observed()), 32'd0);
        release_reset();

        run(6'h23, 6'h00, 0, 0, 0);
        run(6'h04, 6'h00, 0, 0, 1);
        run(6'h04, 6'h00, 0, 0, 0);
        run(6'h05, 6'h00, 0, 0, 1);
        run(6'h05, 6'h00, 0, 0, 0);
        run(6'h2b, 6'h00, 0, 3, 0);
        run(6'h03, 6'h00, 0, 0, 0);
        run(6'h00, 6'h08, 0, 0, 0);
        run(6'h00, 6'h20, 2, 0, 0);
        run(6'h3f, 6'h00, 0, 0, 0);
        run(6'h08, 6'h00, 1, 0, 0);

        // reset dropped between edges during a MEMRD wait
        gen_instr(6'h23, 6'h00, 1, 3, 0);
        while (q.size() > 0 && !(q[0].st == 4'd4)) step(q.pop_front());
        step(q.pop_front());
        q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_outs", 32'(observed()), 32'd0);
        @(posedge clk);
        #1;
        check("held_reset_state", 32'(state), 32'd0);
        check("held_reset_outs", 32'(observed()), 32'd0);
        release_reset();

        for (int n = 0; n < 300; n++) begin
            logic [5:0] opc;
            logic [5:0] fn;
            opc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
            fn  = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
            run(opc, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  6  IR[31:26].
REQ-005 funct  input  6  IR[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory done; 1 completes the current access this cycle.
REQ-008 pc_en  output  1  PC load enable.
REQ-009 IorD, ALUSrcA  output  1 each  2:1 mux selects (0 = PC / PC, 1 = ALUOut / A).
REQ-010 MemRead, MemWrite, IRWrite, RegWrite  output  1 each  strobes.
REQ-011 RegDst  output  2  3:1 select: 0 = rt, 1 = rd, 2 = $31.
REQ-012 MemtoReg  output  2  3:1 select: 0 = ALUOut, 1 = MDR, 2 = PC.
REQ-013 ALUSrcB  output  2  4:1 select: 0 = B, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
REQ-014 PCSource  output  2  3:1 select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
REQ-015 ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode, 11 = pass A.
REQ-016 illegal_op  output  1  unsupported opcode flag.
REQ-017 state  output  4  current state, for debug.

Function
REQ-018 The block SHALL be a Moore FSM with 4-bit state encoding.
- RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BRANCH=9, JUMP=10, AEX=11, AWB=12, JAL=13, JR=14.
- Code 15 is unreachable and SHALL go to FETCH with all outputs 0.
REQ-019 Every output not listed for a state SHALL be 0.
- 3:1 selects SHALL never be driven to 3.
REQ-020 RESET: all outputs 0; next state FETCH.
REQ-021 FETCH: MemRead=1, ALUSrcB=1, ALUOp=00, PCSource=0.
- IRWrite and pc_en SHALL equal mem_ready.
- Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-022 DECODE: ALUSrcB=3, ALUOp=00. Next state by op:
- 100011 or 101011 -> MEMADR.
- 000000 -> JR when funct=001000, otherwise REX.
- 000100 or 000101 -> BRANCH.
- 001000 -> AEX; 000010 -> JUMP; 000011 -> JAL.
- Any other op -> FETCH with illegal_op=1 for this DECODE cycle only.
REQ-023 MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next: MEMRD for op 100011, MEMWR for op 101011.
REQ-024 MEMRD: IorD=1, MemRead=1. Hold while mem_ready=0, then go to MEMWB.
REQ-025 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
REQ-026 MEMWR: IorD=1, MemWrite=1. MemWrite stays asserted while mem_ready=0; go to FETCH when mem_ready=1.
REQ-027 REX: ALUSrcA=1, ALUSrcB=0, ALUOp=10. Next: RWB.
REQ-028 RWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
REQ-029 AEX: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next: AWB.
REQ-030 AWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCSource=1.
- pc_en = zero when op=000100; pc_en = ~zero when op=000101.
- This is the only combinational input-to-output path besides the mem_ready gating. Next: FETCH.
REQ-032 JUMP: PCSource=2, pc_en=1. Next: FETCH.
REQ-033 JAL: PCSource=2, pc_en=1, RegDst=2, MemtoReg=2, RegWrite=1.
- The $31 write captures the pre-load PC (PC+4) on the same edge. Next: FETCH.
REQ-034 JR: ALUSrcA=1, ALUOp=11, PCSource=0, pc_en=1. Next: FETCH.
REQ-035 Cycle counts with mem_ready=1 every cycle:
- lw 5; sw, R-type, addi 4; beq, bne, j, jal, jr 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-036 op and funct SHALL be sampled only in DECODE, MEMADR and BRANCH; they are stable from IRWrite until the next FETCH.

Reset
REQ-037 rst_n=0 SHALL force state=RESET immediately, without waiting for a clock edge, and drive all outputs to 0.
REQ-038 Reset asserted mid-instruction, including during a mem_ready wait, SHALL abandon the instruction. No strobe SHALL be asserted until FETCH.
REQ-039 After rst_n rises, the first edge SHALL move RESET to FETCH.

Verification
REQ-040 Release reset with mem_ready=1 and op=100011 -> state sequence 0,1,2,3,4,5,1; RegWrite=1 with MemtoReg=1 only in state 5.
REQ-041 op=000100: zero=1 in BRANCH -> pc_en=1 with PCSource=1; repeat with zero=0 -> pc_en=0; op=000101 gives the inverse.
REQ-042 op=101011, mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-043 op=000011 -> JAL cycle shows RegDst=2, MemtoReg=2, RegWrite=1, pc_en=1, PCSource=2; op=000000 with funct=001000 -> state 14 with ALUOp=11.
REQ-044 op=111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, no RegWrite or MemWrite.
REQ-045 Drop rst_n between edges while in MEMRD with mem_ready=0 -> state=0 and all outputs 0 immediately; after release, FETCH follows one edge later.
